// File: rtl/rst_sequencer.sv
// Reset sequencer: synchronises REQ_N, holds all channels in reset, then releases them in index order.
// Optional request filter enabled by defining RST_SEQ_FILTER_EN.
module rst_sequencer #(
    parameter int NUM_CH      = 4,
    parameter int SYNC_STAGES = 2,
    parameter int HOLD_CYCLES = 16,
    parameter int GAP_CYCLES  = 4,
    parameter int FILTER_LEN  = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              REQ_N,
    output logic [NUM_CH-1:0] RSTN_OUT,
    output logic              DONE,
    output logic              BUSY
);

    localparam int MAX_HG = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int MAX_V  = (MAX_HG > FILTER_LEN) ? MAX_HG : FILTER_LEN;
    localparam int CW     = $clog2(MAX_V + 1);
    localparam int IW     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [NUM_CH-1:0] ONE = NUM_CH'(1);

    typedef enum logic [1:0] {
        S_ASSERT,
        S_HOLD,
        S_GAP,
        S_DONE
    } state_t;

    state_t                   state_q, state_d;
    logic [CW-1:0]            cnt_q, cnt_d;
    logic [IW-1:0]            idx_q, idx_d;
    logic [NUM_CH-1:0]        rstn_q, rstn_d;
    logic                     done_d, busy_d;
    logic [SYNC_STAGES-1:0]   sync_q;
    logic                     req_s;

    assign req_s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge CLK) begin
        if (RST) begin
            sync_q  <= '0;
            state_q <= S_ASSERT;
            cnt_q   <= '0;
            idx_q   <= '0;
            rstn_q  <= '0;
            DONE    <= 1'b0;
            BUSY    <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], REQ_N};
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            rstn_q  <= rstn_d;
            DONE    <= done_d;
            BUSY    <= busy_d;
        end
    end

    assign RSTN_OUT = rstn_q;

    // A low synchronised request overrides every state; otherwise release one channel per expiry.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        rstn_d  = rstn_q;
        if (!req_s) begin
            state_d = S_ASSERT;
            cnt_d   = '0;
            idx_d   = '0;
            rstn_d  = '0;
        end else begin
            case (state_q)
                S_ASSERT: begin
                    rstn_d = '0;
`ifdef RST_SEQ_FILTER_EN
                    if (cnt_q == CW'(FILTER_LEN - 1)) begin
                        state_d = S_HOLD;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
`else
                    state_d = S_HOLD;
                    cnt_d   = '0;
`endif
                end
                S_HOLD: begin
                    if (cnt_q == CW'(HOLD_CYCLES - 1)) begin
                        rstn_d  = ONE;
                        idx_d   = IW'(1);
                        cnt_d   = '0;
                        state_d = (NUM_CH == 1) ? S_DONE : S_GAP;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                S_GAP: begin
                    if (cnt_q == CW'(GAP_CYCLES - 1)) begin
                        rstn_d = (rstn_q << 1) | ONE;
                        cnt_d  = '0;
                        if (idx_q == IW'(NUM_CH - 1)) begin
                            state_d = S_DONE;
                        end else begin
                            idx_d = idx_q + IW'(1);
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                S_DONE: begin
                    rstn_d = '1;
                end
                default: begin
                    state_d = S_ASSERT;
                    cnt_d   = '0;
                    idx_d   = '0;
                    rstn_d  = '0;
                end
            endcase
        end
        done_d = (state_d == S_DONE);
        busy_d = (state_d == S_HOLD) || (state_d == S_GAP);
    end

endmodule

// File: tb/tb_rst_sequencer.sv
// Self-checking bench for rst_sequencer: a default 4-channel instance and a 1-channel, 1-cycle-hold instance
// are checked every cycle against a model derived from the count of consecutive high synchronised requests.
module tb_rst_sequencer;

    localparam int SYNC  = 2;
    localparam int HOLD  = 16;
    localparam int GAP   = 4;
    localparam int FLEN  = 8;
`ifdef RST_SEQ_FILTER_EN
    localparam int FILT  = FLEN;
`else
    localparam int FILT  = 1;
`endif

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       REQ_N = 1'b1;
    logic [3:0] rstn4;
    logic       done4, busy4;
    logic [0:0] rstn1;
    logic       done1, busy1;

    int checks = 0;
    int errors = 0;

    bit [SYNC-1:0] pipe = '0;
    int            run = 0;

    always #5 CLK = ~CLK;

    rst_sequencer #(
        .NUM_CH(4), .SYNC_STAGES(SYNC), .HOLD_CYCLES(HOLD), .GAP_CYCLES(GAP), .FILTER_LEN(FLEN)
    ) dut4 (
        .CLK(CLK), .RST(RST), .REQ_N(REQ_N), .RSTN_OUT(rstn4), .DONE(done4), .BUSY(busy4)
    );

    rst_sequencer #(
        .NUM_CH(1), .SYNC_STAGES(SYNC), .HOLD_CYCLES(1), .GAP_CYCLES(GAP), .FILTER_LEN(FLEN)
    ) dut1 (
        .CLK(CLK), .RST(RST), .REQ_N(REQ_N), .RSTN_OUT(rstn1), .DONE(done1), .BUSY(busy1)
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Channels released after `r` consecutive high synchronised samples seen by the sequencer.
    function automatic int releasedCount(int r, int numCh, int hold, int gap);
        int n;
        if (r < FILT + hold) return 0;
        n = 1 + (r - FILT - hold) / gap;
        return (n > numCh) ? numCh : n;
    endfunction

    task automatic updateModel(input logic rstVal);
        if (rstVal) begin
            pipe = '0;
            run  = 0;
        end else begin
            if (pipe[SYNC-1]) begin
                if (run < 1000000) run++;
            end else begin
                run = 0;
            end
            pipe = {pipe[SYNC-2:0], REQ_N};
        end
    endtask

    task automatic checkAll();
        int n4, n1;
        n4 = releasedCount(run, 4, HOLD, GAP);
        n1 = releasedCount(run, 1, 1, GAP);
        checkOutput("rstn4", 32'(rstn4), 32'((1 << n4) - 1));
        checkOutput("done4", 32'(done4), 32'(n4 == 4));
        checkOutput("busy4", 32'(busy4), 32'((run >= FILT) && (n4 < 4)));
        checkOutput("rstn1", 32'(rstn1), 32'((1 << n1) - 1));
        checkOutput("done1", 32'(done1), 32'(n1 == 1));
        checkOutput("busy1", 32'(busy1), 32'((run >= FILT) && (n1 < 1)));
    endtask

    task automatic applyStimulus(input logic rstVal, input logic reqVal, input int cycles);
        RST   = rstVal;
        REQ_N = reqVal;
        repeat (cycles) begin
            @(posedge CLK);
            updateModel(rstVal);
            @(negedge CLK);
            checkAll();
        end
    endtask

    initial begin
        @(negedge CLK);
        applyStimulus(1'b1, 1'b0, 1);
        applyStimulus(1'b1, 1'b1, 1);
        applyStimulus(1'b1, 1'b0, 1);
        applyStimulus(1'b0, 1'b1, 40);
        applyStimulus(1'b0, 1'b0, 1);
        applyStimulus(1'b0, 1'b1, 40);
        applyStimulus(1'b0, 1'b0, 1);
        applyStimulus(1'b0, 1'b1, 24);
        applyStimulus(1'b0, 1'b0, 2);
        applyStimulus(1'b0, 1'b1, 45);
        applyStimulus(1'b0, 1'b1, 5);
        applyStimulus(1'b0, 1'b0, 1);
        applyStimulus(1'b0, 1'b1, 50);
        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 19) == 0) begin
                applyStimulus(1'b1, 1'($urandom_range(0, 1)), $urandom_range(1, 3));
            end else begin
                applyStimulus(1'b0, 1'b0, $urandom_range(1, 4));
            end
            applyStimulus(1'b0, 1'b1, $urandom_range(1, 45));
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rst_sequencer.md
Name: rst_sequencer

Overview:
- Parametrised successor to the single-output reset synchroniser.
- Synchronises an external active-low reset request `REQ_N` into the `CLK` domain.
- Asserts reset to the first `NUM_CH` downstream blocks together on request, then releases them one at a time in index order, with programmable hold and gap times.
- Sits at the top of the FIFO test system and drives the per-block reset inputs (write side, read side, flag logic, display) so they come out of reset in a fixed order.

Parameters:
- `NUM_CH`, 4: number of sequenced active-low reset outputs; must be ≥ 1.
- `SYNC_STAGES`, 2: synchroniser flop count on `REQ_N`; must be ≥ 2.
- `HOLD_CYCLES`, 16: cycles from leaving S_ASSERT until channel 0 releases; must be ≥ 1.
- `GAP_CYCLES`, 4: cycles between release of channel i-1 and channel i; must be ≥ 1.
- `FILTER_LEN`, 8: stability window for the request filter; used only when `RST_SEQ_FILTER_EN` is defined; must be ≥ 1.

Ports:
- `CLK`  input  1  single clock for all logic.
- `RST`  input  1  synchronous, active-high master reset.
- `REQ_N`  input  1  asynchronous active-low reset request (0 = hold downstream in reset).
- `RSTN_OUT`  output  `NUM_CH`  per-channel active-low reset; bit 0 releases first.
- `DONE`  output  1  high when every channel is released.
- `BUSY`  output  1  high while in S_HOLD or S_GAP.

Behaviour:
- Clocking and reset:
  - Single clock `CLK`. All state updates on the rising edge of `CLK`.
  - `RST` is synchronous and active-high, and has priority over everything else.
  - On an edge with `RST`=1: sync flops ← 0, state ← S_ASSERT, counters ← 0, `RSTN_OUT` ← all 0, `DONE` ← 0, `BUSY` ← 0.
- Synchroniser:
  - `REQ_N` passes through `SYNC_STAGES` flops; the last stage is `req_s`.
  - The FSM uses `req_s` only. `REQ_N` is never used combinationally.
- Request assertion (every state):
  - If `req_s`=0 on an edge, the next state is S_ASSERT.
  - On that same edge `RSTN_OUT` ← all 0, `DONE` ← 0, `BUSY` ← 0, and the counter and channel index clear.
  - Latency from a `REQ_N` fall to `RSTN_OUT` low is `SYNC_STAGES`+1 edges, in any state.
- State machine:
  - S_ASSERT: `RSTN_OUT` is all 0. Exit to S_HOLD when `req_s`=1 (see Optional Feature); on entry cnt ← 0.
  - S_HOLD: cnt increments each edge. On the edge where cnt = `HOLD_CYCLES`-1:
    - `RSTN_OUT[0]` ← 1 and idx ← 1.
    - Next state is S_DONE if `NUM_CH`=1, otherwise S_GAP with cnt ← 0.
  - S_GAP: cnt increments each edge. On the edge where cnt = `GAP_CYCLES`-1:
    - `RSTN_OUT[idx]` ← 1 and cnt ← 0.
    - If idx = `NUM_CH`-1, next state is S_DONE; otherwise idx increments.
  - S_DONE: all outputs stay released; `DONE`=1. Leaves only on `req_s`=0 or `RST`.
- Timing:
  - `RSTN_OUT[0]` rises exactly `HOLD_CYCLES` edges after the edge that enters S_HOLD.
  - `RSTN_OUT[i]` rises exactly `GAP_CYCLES` edges after `RSTN_OUT[i-1]`.
  - `DONE` rises on the same edge as `RSTN_OUT[NUM_CH-1]`.
- Output invariants:
  - Released bits stay released (monotonic) until the next request or `RST`.
  - `RSTN_OUT` is always thermometer-coded: bit i=1 implies every bit below i is 1.
  - All outputs are registered; there are no combinational paths from inputs to outputs.
- Counter width: `$clog2(max(HOLD_CYCLES, GAP_CYCLES, FILTER_LEN)+1)`. The index counter is `$clog2(NUM_CH)` wide, minimum 1.
- Mid-sequence request: a `req_s` drop during S_HOLD or S_GAP aborts the sequence, re-asserts every channel, and restarts from S_ASSERT. There is no partial resume.

Optional Feature:
- Macro: `RST_SEQ_FILTER_EN`.
- Defined:
  - S_ASSERT exits only after `req_s`=1 on `FILTER_LEN` consecutive edges.
  - The stability counter clears on any `req_s`=0.
  - The edge that enters S_HOLD is the `FILTER_LEN`-th consecutive high sample.
  - Request assertion is still immediate, unfiltered.
- Not defined: S_ASSERT exits on the first edge with `req_s`=1, and the filter counter is not built.

Test Plan (defaults unless stated; edge 0 = first edge with `RST`=0 and `REQ_N`=1 held):
- Hold `RST`=1 for 3 cycles with `REQ_N` toggling → `RSTN_OUT`=4'b0000, `DONE`=0, `BUSY`=0 throughout.
- Release `RST` with `REQ_N`=1 held, filter off:
  - `req_s` high after edge 1; S_HOLD entered on edge 2.
  - `RSTN_OUT`: 0001 at edge 18, 0011 at edge 22, 0111 at edge 26, 1111 at edge 30.
  - `DONE`=1 from edge 30.
- From S_DONE, drive `REQ_N`=0 for 1 cycle → `RSTN_OUT`=0000 and `DONE`=0 exactly 3 edges later; after `REQ_N` returns high, the full 4-step sequence repeats with the same spacing.
- Drop `REQ_N` while `RSTN_OUT`=0011 → all bits return to 0 three edges later; after `REQ_N` returns high, the sequence restarts from channel 0 with a full `HOLD_CYCLES` wait.
- With `RST_SEQ_FILTER_EN`, `FILTER_LEN`=8:
  - `REQ_N` high for 5 cycles, low for 1, then held high → no exit from S_ASSERT until 8 consecutive high `req_s` samples.
  - `RSTN_OUT[0]` then rises 16 edges after S_HOLD entry.
- `NUM_CH`=1, `HOLD_CYCLES`=1 → `RSTN_OUT[0]` and `DONE` rise together 1 edge after S_HOLD entry; S_GAP is never entered.
